// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives the instruction memory address and buffers
// {pc, instr} pairs for decode. Optional performance counters are enabled by FETCH_PERF_CNT_EN.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_flush,
`endif
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pc_q,     pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [31:0]      mem_pc_q    [DEPTH];
    logic [31:0]      mem_instr_q [DEPTH];

    logic             pop_s;
    logic             push_s;
    logic             full_s;

    assign full_s    = (count_q == CNT_W'(DEPTH));
    assign pop_s     = out_valid & out_ready;
    assign push_s    = !redirect & (!full_s | pop_s);

    assign imem_addr    = pc_q;
    assign out_valid    = (count_q != CNT_W'(0));
    assign out_instr    = mem_instr_q[rd_ptr_q];
    assign out_pc       = mem_pc_q[rd_ptr_q];
    assign out_pc_plus4 = mem_pc_q[rd_ptr_q] + 32'd4;
    assign count        = count_q;

    // Next-state for PC, pointers and occupancy; redirect overrides push and pop.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            // Masking keeps the target word-aligned while every input bit stays in use.
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (push_s) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                pc_d     = pc_q;
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= 32'h0000_0000;
                mem_instr_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_instr_q[wr_ptr_q] <= imem_instr;
        end else begin
            mem_pc_q[wr_ptr_q]    <= mem_pc_q[wr_ptr_q];
            mem_instr_q[wr_ptr_q] <= mem_instr_q[wr_ptr_q];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Performance counters survive redirects; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_stall_q   <= 32'h0000_0000;
            perf_flush_q   <= 32'h0000_0000;
        end else begin
            perf_fetched_q <= perf_fetched_q + (push_s ? 32'd1 : 32'd0);
            perf_stall_q   <= perf_stall_q + ((full_s & !pop_s & !redirect) ? 32'd1 : 32'd0);
            perf_flush_q   <= perf_flush_q + (redirect ? 32'd1 : 32'd0);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue; instruction memory returns addr >> 2.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [2:0]  count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int checks   = 0;
    int failures = 0;

    instr_fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4),
        .CNT_W    (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush),
`endif
        .count        (count)
    );

    assign imem_instr = imem_addr >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, pc >> 2);
        chk({tag, "_pc4"}, out_pc_plus4, pc + 32'd4);
        chk({tag, "_count"}, {29'd0, count}, {29'd0, cnt});
    endtask

    task automatic empty(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_count"}, {29'd0, count}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        out_ready   = 1'b1;

        // Reset state
        @(negedge clk);
        empty("rst");
        chk("rst_imem_addr", imem_addr, 32'h0000_0000);
        chk("rst_out_pc", out_pc, 32'h0000_0000);
        chk("rst_out_instr", out_instr, 32'h0000_0000);

        // Streaming with out_ready=1: one instruction per cycle, count stays 1
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            head($sformatf("stream%0d", k), 32'(k * 4), 3'd1);
        end

        // Fill with out_ready=0, then drain without gap
        rst_n = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            head($sformatf("fill%0d", k), 32'h0000_0000, (k < 4) ? 3'(k) : 3'd4);
        end
        chk("full_imem_addr", imem_addr, 32'h0000_0010);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            head($sformatf("drain%0d", k), 32'(k * 4), 3'd4);
            chk($sformatf("drain%0d_addr", k), imem_addr, 32'h0000_0010 + 32'(k * 4));
        end

        // Asynchronous reset mid-stream with count=3
        rst_n = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_arst_count", {29'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        empty("arst");
        chk("arst_imem_addr", imem_addr, 32'h0000_0000);
        chk("arst_out_pc", out_pc, 32'h0000_0000);
`ifdef FETCH_PERF_CNT_EN
        chk("arst_perf_fetched", perf_fetched, 32'd0);
        chk("arst_perf_stall", perf_stall, 32'd0);
        chk("arst_perf_flush", perf_flush, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_redir_count", {29'd0, count}, 32'd3);

        // Redirect with unaligned target; same-cycle pop is discarded
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        out_ready   = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        empty("redir");
        chk("redir_imem_addr", imem_addr, 32'h0000_0100);
        @(negedge clk);
        head("redir_tgt", 32'h0000_0100, 3'd1);

        // Back-to-back redirects: last one wins
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        empty("redir2a");
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        redirect = 1'b0;
        empty("redir2b");
        chk("redir2_imem_addr", imem_addr, 32'h0000_0300);
        @(negedge clk);
        head("redir2_tgt", 32'h0000_0300, 3'd1);

        // PC wraps modulo 2^32
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        empty("wrap_flush");
        @(negedge clk);
        head("wrap0", 32'hFFFF_FFF8, 3'd1);
        @(negedge clk);
        head("wrap1", 32'hFFFF_FFFC, 3'd1);
        @(negedge clk);
        head("wrap2", 32'h0000_0000, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipelined CPU's IF/ID register.
- Owns the program counter and drives the combinational instruction memory address.
- Buffers fetched {pc, instr} pairs in a small FIFO so decode can stall without losing instructions.
- Accepts a redirect (branch/jump target) from later stages that flushes the queue and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 4, FIFO entries; power of two, range 2..16.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  32  instruction memory address; equals current PC.
- imem_instr  input  32  instruction word; combinational from imem_addr in the same cycle.
- redirect  input  1  flush queue and load redirect_pc.
- redirect_pc  input  32  new fetch address.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts head entry this cycle.
- out_instr  output  32  head instruction.
- out_pc  output  32  PC of head instruction.
- out_pc_plus4  output  32  out_pc + 4, for link/branch use.
- count  output  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC, FIFO empty, rd/wr pointers 0, out_valid=0, count=0, out_instr=0, out_pc=0.
- imem_addr = PC, combinational.
- pop = out_valid & out_ready.
- push = !redirect & ((count < DEPTH) | pop).
- On push: write {PC, imem_instr} at wr_ptr, wr_ptr++, PC <= PC+4.
- Without push and without redirect, PC holds.
- Push and pop in the same cycle: count unchanged. This is legal when the FIFO is full.
- Outputs come combinationally from the FIFO head: out_valid = (count != 0).
- Latency: the first out_valid rises on the first rising edge after rst_n deasserts. From then on, one instruction per cycle while out_ready=1.
- Redirect has priority over everything:
  - Pointers and count are cleared.
  - PC <= {redirect_pc[31:2], 2'b00}; low bits are forced to zero.
  - No push that cycle, and any pop that cycle is discarded.
  - out_valid=0 the following cycle; the target instruction is valid one cycle later.
- Redirect on consecutive cycles: the last one wins; the queue stays empty.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- Pointers wrap modulo DEPTH.
- Held-off data: while out_valid=1 and out_ready=0, out_instr and out_pc are stable (no redirect).
- Full: when count==DEPTH and out_ready=0, no fetch occurs, PC holds, and imem_addr is stable.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). In-flight entries are lost.
- X on imem_instr while push=0 has no effect.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_fetched (32): pushes.
  - perf_stall (32): cycles with count==DEPTH & !pop & !redirect.
  - perf_flush (32): redirect cycles.
- Counters reset to 0 on rst_n, wrap modulo 2^32, and are never cleared by redirect.
- When not defined, these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0, imem returning addr>>2, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles; out_instr 0,1,2,3; count stays 1.
- out_ready=0 from reset for 6 cycles -> count 1,2,3,4,4,4; imem_addr holds 32'h10. Then out_ready=1 -> out_pc 0,4,8,12,16 with no gap.
- Full FIFO with out_ready=1 for one cycle -> count stays 4, PC advances 32'h10->32'h14.
- redirect=1, redirect_pc=32'h0000_0103 while count=3 -> next cycle count=0, out_valid=0, imem_addr=32'h100; following cycle out_pc=32'h100.
- redirect_pc=32'hFFFF_FFF8 with out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n pulsed low mid-stream with count=3 -> out_valid=0, count=0, imem_addr=RESET_PC without waiting for a clock edge; with FETCH_PERF_CNT_EN, the perf counters read 0.
